// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the Wishbone multi-master arbiter family.
package wb_arbiter_pkg;

  typedef enum logic {ARB_RR, ARB_PRIO} arb_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_OWNED, ST_ABORT} arb_state_t;

  localparam int unsigned MAX_N = 16;

  function automatic logic [3:0] onehot2bin(input logic [MAX_N-1:0] oh);
    logic [3:0] b;
    b = '0;
    for (int unsigned i = 0; i < MAX_N; i++)
      if (oh[i]) b = b | 4'(i);
    return b;
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Master-side bundle of the arbiter: per-master CYC/enable in, grant/owner/CYC/error out.
interface wb_arbiter_if #(
  parameter int unsigned N = 2
);
  localparam int unsigned OW = $clog2(N);

  logic [N-1:0]  cyc_i;
  logic [N-1:0]  en_i;
  logic          cyc_common_o;
  logic [N-1:0]  gnt_o;
  logic [OW-1:0] owner_o;
  logic [N-1:0]  err_o;

  modport slave  (input cyc_i, en_i, output cyc_common_o, gnt_o, owner_o, err_o);
  modport master (output cyc_i, en_i, input cyc_common_o, gnt_o, owner_o, err_o);

endinterface

// File: rtl/wb_arbiter_pick.sv
// Combinational next-token selection: round-robin after the current holder, or lowest index wins.
module wb_arbiter_pick
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter arb_mode_t   MODE = ARB_RR
) (
  input  logic [N-1:0] req_i,
  input  logic [N-1:0] token_i,
  output logic [N-1:0] token_o
);

  logic [N-1:0] shifted;
  logic         found;
  int unsigned  start;
  int unsigned  idx;

  // Both policies are one cyclic scan; only the starting position differs.
  always_comb begin
    token_o = token_i;
    found   = 1'b0;
    shifted = '0;
    idx     = 0;
    start   = (MODE == ARB_RR) ? 32'(onehot2bin(MAX_N'(token_i))) + 1 : 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx     = (start + k) % N;
      shifted = req_i >> idx;
      if (!found && shifted[0]) begin
        token_o = N'(1) << idx;
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_to.sv
// Wishbone N-master arbiter with enable mask and bus-hold watchdog that aborts and
// blocks a master whose cycle runs for TIMEOUT clocks.
module wb_arbiter_to
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned N       = 2,
  parameter arb_mode_t   MODE    = ARB_RR,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  wb_arbiter_if.slave  bus
);

  localparam int unsigned    OW   = $clog2(N);
  localparam int unsigned    TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0]  TLIM = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t    state_q, state_d;
  logic [N-1:0]  token_q, token_d;
  logic [N-1:0]  blocked_q, blocked_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          active_q;

  logic [N-1:0]  req;
  logic [N-1:0]  pick;
  logic          aborting;
  logic          hold_cyc, hold_en, hold_blk;
  logic          cyc_common;
  logic          timeout_hit;

  assign aborting = (state_q == ST_ABORT);

  // Token is one-hot, so masking with it selects the holder's bit without indexing.
  assign hold_cyc = |(bus.cyc_i & token_q);
  assign hold_en  = |(bus.en_i & token_q);
  assign hold_blk = |(blocked_q & token_q);

  assign cyc_common = hold_cyc & ~hold_blk & (hold_en | active_q) & ~aborting & ~rst_i;

  assign req = bus.cyc_i & bus.en_i & ~blocked_q & ~token_q;

  assign timeout_hit = (TIMEOUT != 0) && cyc_common && (tcnt_q == TLIM);

  wb_arbiter_pick #(
    .N    (N),
    .MODE (MODE)
  ) u_pick (
    .req_i   (req),
    .token_i (token_q),
    .token_o (pick)
  );

  always_comb begin
    state_d   = state_q;
    token_d   = token_q;
    blocked_d = blocked_q & bus.cyc_i;
    tcnt_d    = '0;
    if (cyc_common) begin
      tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);
    end else begin
      token_d = pick;
    end
    if (timeout_hit) blocked_d = blocked_d | token_q;
    case (state_q)
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = timeout_hit ? ST_ABORT : (cyc_common ? ST_OWNED : ST_IDLE);
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      token_q   <= N'(1);
      blocked_q <= '0;
      tcnt_q    <= '0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      token_q   <= token_d;
      blocked_q <= blocked_d;
      tcnt_q    <= tcnt_d;
      active_q  <= cyc_common;
    end
  end

  assign bus.cyc_common_o = cyc_common;
  assign bus.gnt_o        = token_q;
  assign bus.owner_o      = OW'(onehot2bin(MAX_N'(token_q)));
  assign bus.err_o        = (aborting && !rst_i) ? token_q : '0;

endmodule

// File: tb/tb_wb_arbiter_to.sv
// Directed scenarios for wb_arbiter_to (N=4, TIMEOUT=8) in both arbitration modes.
module tb_wb_arbiter_to;
  import wb_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] cyc;
  logic [3:0] en;

  always #5 clk = ~clk;

  wb_arbiter_if #(.N(4)) if_rr ();
  wb_arbiter_if #(.N(4)) if_pr ();

  assign if_rr.cyc_i = cyc;
  assign if_rr.en_i  = en;
  assign if_pr.cyc_i = cyc;
  assign if_pr.en_i  = en;

  wb_arbiter_to #(.N(4), .MODE(ARB_RR), .TIMEOUT(8)) dut_rr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_rr.slave)
  );

  wb_arbiter_to #(.N(4), .MODE(ARB_PRIO), .TIMEOUT(8)) dut_pr (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_pr.slave)
  );

  typedef struct {
    logic [3:0] cyc;
    logic [3:0] en;
    logic       rst;
    logic [3:0] gnt;
    logic       cc;
    logic [3:0] err;
    logic       chk_gnt;
  } step_t;

  typedef struct {
    logic [10:0] val;
    logic [10:0] mask;
  } exp_t;

  step_t plan[$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic logic [1:0] idx_of(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic add(input logic [3:0] c, input logic [3:0] e, input logic [3:0] g,
                     input logic cc, input logic [3:0] er);
    step_t s;
    s = '{cyc: c, en: e, rst: 1'b0, gnt: g, cc: cc, err: er, chk_gnt: 1'b1};
    plan.push_back(s);
  endtask

  task automatic add_rst(input logic [3:0] c, input logic [3:0] g, input logic chk);
    step_t s;
    s = '{cyc: c, en: 4'b1111, rst: 1'b1, gnt: g, cc: 1'b0, err: 4'b0000, chk_gnt: chk};
    plan.push_back(s);
  endtask

  task automatic apply(input step_t s);
    exp_t e;
    cyc = s.cyc;
    en  = s.en;
    rst = s.rst;
    e.val  = {s.gnt, idx_of(s.gnt), s.cc, s.err};
    e.mask = {{6{s.chk_gnt}}, 5'b11111};
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc = 4'b0000;
    en  = 4'b1111;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    add_rst(4'b0001, 4'b0001, 1'b1);
    add_rst(4'b0001, 4'b0001, 1'b1);
    repeat (2) add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL reset step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rr_order();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    add(4'b1110, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    repeat (3) add(4'b1110, 4'b1111, 4'b0010, 1'b1, 4'b0000);
    add(4'b1100, 4'b1111, 4'b0010, 1'b0, 4'b0000);
    repeat (3) add(4'b1110, 4'b1111, 4'b0100, 1'b1, 4'b0000);
    add(4'b1010, 4'b1111, 4'b0100, 1'b0, 4'b0000);
    repeat (3) add(4'b1110, 4'b1111, 4'b1000, 1'b1, 4'b0000);
    add(4'b0110, 4'b1111, 4'b1000, 1'b0, 4'b0000);
    add(4'b1110, 4'b1111, 4'b0010, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0010, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL rr_order step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_prio();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    add(4'b1010, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    repeat (2) add(4'b1010, 4'b1111, 4'b0010, 1'b1, 4'b0000);
    add(4'b1000, 4'b1111, 4'b0010, 1'b0, 4'b0000);
    add(4'b1000, 4'b1111, 4'b1000, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b1000, 1'b0, 4'b0000);
    add(4'b0010, 4'b1111, 4'b1000, 1'b0, 4'b0000);
    add(4'b0111, 4'b1111, 4'b0010, 1'b1, 4'b0000);
    add(4'b0101, 4'b1111, 4'b0010, 1'b0, 4'b0000);
    add(4'b0101, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_pr.gnt_o, if_pr.owner_o, if_pr.cyc_common_o, if_pr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL prio step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    add(4'b0100, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    repeat (2) add(4'b0100, 4'b1111, 4'b0100, 1'b1, 4'b0000);
    repeat (6) add(4'b0101, 4'b1111, 4'b0100, 1'b1, 4'b0000);
    add(4'b0101, 4'b1111, 4'b0100, 1'b0, 4'b0100);
    add(4'b0101, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    repeat (3) add(4'b0100, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0100, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0100, 4'b1111, 4'b0100, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0100, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL timeout step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout_edge();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    repeat (7) add(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0001, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL timeout_edge step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_enable();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    repeat (3) add(4'b0100, 4'b1011, 4'b0001, 1'b0, 4'b0000);
    add(4'b0100, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0100, 4'b1111, 4'b0100, 1'b1, 4'b0000);
    add(4'b0100, 4'b1011, 4'b0100, 1'b1, 4'b0000);
    add(4'b0000, 4'b1011, 4'b0100, 1'b0, 4'b0000);
    add(4'b0100, 4'b1011, 4'b0100, 1'b0, 4'b0000);
    add(4'b0000, 4'b1111, 4'b0100, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL enable step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midcycle();
    step_t s; exp_t e; logic [10:0] obs; int k = 0;
    do_reset();
    add(4'b1000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b1000, 4'b1111, 4'b1000, 1'b1, 4'b0000);
    add_rst(4'b1001, 4'b1000, 1'b0);
    repeat (2) add(4'b1001, 4'b1111, 4'b0001, 1'b1, 4'b0000);
    add(4'b1000, 4'b1111, 4'b0001, 1'b0, 4'b0000);
    add(4'b0000, 4'b1111, 4'b1000, 1'b0, 4'b0000);
    while (plan.size() != 0) begin
      s = plan.pop_front(); apply(s);
      @(negedge clk);
      obs = {if_rr.gnt_o, if_rr.owner_o, if_rr.cyc_common_o, if_rr.err_o};
      e = sb.pop_front(); n_cmp++;
      if ((obs & e.mask) !== (e.val & e.mask)) begin
        n_bad++;
        $display("FAIL reset_mid step %0d: gnt/own/cyc/err got %b required %b", k, obs, e.val);
      end
      k++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc = 4'b0000;
    en  = 4'b1111;
    @(posedge clk); #1;
    test_reset();
    test_rr_order();
    test_prio();
    test_timeout();
    test_timeout_edge();
    test_enable();
    test_reset_midcycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_to.md
# wb_arbiter_to

Parametrised Wishbone multi-master arbiter with selectable round-robin or fixed-priority policy, per-master enable mask and bus-hold timeout. It sits between N Wishbone masters and the shared interconnect. It produces a one-hot grant, a common CYC and the owner index, and it forcibly ends any cycle that exceeds TIMEOUT clocks, flagging the offending master.

## Interface
- N, 2: number of masters, 2..16.
- MODE, ARB_RR: arbitration policy, either ARB_RR (round-robin) or ARB_PRIO (fixed priority, index 0 highest).
- TIMEOUT, 0: maximum clocks a granted cycle may last; 0 disables the watchdog.
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; synchronous and active-high.
- cyc_i  in  N  CYC from each master.
- en_i  in  N  per-master enable; a disabled master cannot win arbitration.
- cyc_common_o  out  1  CYC towards the shared bus.
- gnt_o  out  N  one-hot grant (the token).
- owner_o  out  $clog2(N)  binary index of the bit set in gnt_o.
- err_o  out  N  one-clock timeout pulse to the aborted master.

## Operation
- token_r: one-hot register, reset to bit 0. gnt_o = token_r; owner_o = index of token_r.
- blocked_r[N]: reset 0. active_r (registered cyc_common_o): reset 0. tcnt_r: reset 0.
- Holder index is h. Combinational output: cyc_common_o = cyc_i[h] & ~blocked_r[h] & (en_i[h] | active_r) & ~abort_r.
- en_i only gates the start of a cycle. Dropping en_i[h] mid-cycle does not cut the cycle.
- Request vector for arbitration: req = cyc_i & en_i & ~blocked_r & ~token_r.
- Arbitration happens only at a clock edge where cyc_common_o = 0:
  - ARB_RR: token moves to the first set bit of req, scanning h+1, h+2, ... cyclically.
  - ARB_PRIO: token moves to the lowest set bit of req.
  - If req = 0, the token stays where it is.
- The token never moves while cyc_common_o = 1.
- FSM states:
  - IDLE (cyc_common_o = 0): IDLE -> OWNED when cyc_common_o rises.
  - OWNED (cyc_common_o = 1): OWNED -> IDLE when cyc_i[h] falls. OWNED -> ABORT when tcnt_r reaches TIMEOUT-1 with cyc_common_o still high.
  - ABORT (one clock, abort_r = 1): err_o[h] = 1, blocked_r[h] is set, tcnt_r = 0, then ABORT -> IDLE.
- tcnt_r increments each clock in OWNED and clears in IDLE. Width is $clog2(TIMEOUT+1), saturating.
- blocked_r[i] clears at the first edge where cyc_i[i] = 0. A blocked master cannot hold or win the bus until it deasserts CYC.
- All outputs are 0 during reset except gnt_o, which is 1 (one-hot bit 0), and owner_o, which is 0.

## Timing
- Holder asserts cyc_i: cyc_common_o rises in the same clock (0 latency).
- Non-holder asserts cyc_i while the bus is idle: token moves at the next edge, and cyc_common_o rises 1 clock after the request.
- Holder drops cyc_i: cyc_common_o falls in the same clock, and the token may move at that same edge. Back-to-back hand-over therefore costs 1 idle clock.
- Timeout: cyc_common_o stays high for exactly TIMEOUT clocks. The ABORT cycle follows with err_o high for 1 clock. The token moves at the end of the ABORT cycle.
- Simultaneous events:
  - Holder drops cyc_i in the clock tcnt_r would hit the limit: normal end, no err_o.
  - Blocked master deasserts and reasserts in consecutive clocks: the block clears on the deasserted clock, so the master is eligible again.
- Reset mid-cycle: all state returns to reset values at the next edge, with no err_o pulse.

## Structure
- Package wb_arbiter_pkg holds:
  - the arb_mode_t enum (ARB_RR, ARB_PRIO);
  - the onehot2bin function.
- Sub-module wb_arbiter_pick: purely combinational. Inputs are req, token_r and MODE; output is the next one-hot token. It is reusable by later arbiters.
- The top level holds token_r, blocked_r, tcnt_r, abort_r, active_r and the output logic.

## Test plan
Directed scenarios run with N=4, TIMEOUT=8.
- Reset, then idle: gnt_o=0001, owner_o=0, cyc_common_o=0, err_o=0000.
- ARB_RR, cyc_i=1110 held continuously, each cycle lasting 3 clocks with 1 idle clock between: grant order 1, 2, 3, 1, with hand-over latency 1 clock.
- ARB_PRIO, masters 3 and 1 both requesting while idle: master 1 wins. When master 1 finishes, master 3 gets the grant.
- Master 2 holds cyc_i for 20 clocks: cyc_common_o is high for 8 clocks, then err_o=0100 for 1 clock. A pending master 0 receives the grant. Master 2 stays excluded until its cyc_i drops.
- en_i=1011 with only master 2 requesting: the token never moves to master 2. Setting en_i=1111 grants it 1 clock later.
- rst_i asserted while master 3 owns the bus: the next clock shows gnt_o=0001, cyc_common_o follows cyc_i[0] only, and no err_o pulse occurs.
